// File: rtl/cic3_row_readout.sv
// Readout stage for the CIC3 filter row: decimated capture of the row outputs,
// frame-counter tagging, a small frame FIFO and an MSB-first serializer with a
// sync marker on the first bit of every frame. Single clock domain with the row.
module cic3_row_readout #(
    parameter int unsigned NUM_CHANNELS = 24,
    parameter int unsigned DECIMATION   = 64,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FCNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_CHANNELS-1:0]       filt_in,
    output logic                          ser_data,
    output logic                          ser_valid,
    output logic                          ser_sync,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned W      = FCNT_W + NUM_CHANNELS;
    localparam int unsigned DCNT_W = $clog2(DECIMATION);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BIT_W  = $clog2(W);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIMATION - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    // Decimation and frame counters
    logic [DCNT_W-1:0] decim_q, decim_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              strobe;

    // Frame FIFO
    logic [W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              overflow_q, overflow_d;

    // Serializer
    state_e            state_q, state_d;
    logic [W-1:0]      sreg_q, sreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              bit_last;

    assign strobe     = enable && (decim_q == DCNT_LAST);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign bit_last   = (bit_cnt_q == BIT_LAST);

    // A full FIFO still accepts the new frame when the serializer frees a slot
    // on the same edge; otherwise the frame is dropped.
    assign push = strobe && (!fifo_full || pop);

    // Decimation counter and frame tag; both restart from zero while disabled
    always_comb begin
        decim_d = decim_q;
        fcnt_d  = fcnt_q;
        if (!enable) begin
            decim_d = '0;
            fcnt_d  = '0;
        end else if (strobe) begin
            decim_d = '0;
            // Dropped frames still consume a tag so gaps are visible downstream
            fcnt_d  = fcnt_q + FCNT_W'(1);
        end else begin
            decim_d = decim_q + DCNT_W'(1);
        end
    end

    // Counter state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decim_q <= '0;
            fcnt_q  <= '0;
        end else begin
            decim_q <= decim_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; disable flushes everything
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (!enable) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (strobe && !push) begin
                overflow_d = 1'b1;
            end
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame storage; the captured word is {tag, row outputs} at the strobe edge
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {fcnt_q, filt_in};
        end
    end

    // Serializer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer next state: leave SHIFT after bit 0 unless another frame is queued
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (bit_last && fifo_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Serializer outputs and pop request, decoded from registered state only
    always_comb begin
        ser_valid = 1'b0;
        ser_sync  = 1'b0;
        ser_data  = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                pop = enable && !fifo_empty;
            end
            StShift: begin
                ser_valid = 1'b1;
                ser_sync  = (bit_cnt_q == '0);
                ser_data  = sreg_q[W-1];
                // Popping on the last bit keeps consecutive frames gap-free
                pop       = enable && bit_last && !fifo_empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Shift register and bit position; a pop reloads both
    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        if (pop) begin
            sreg_d    = mem[rd_ptr_q];
            bit_cnt_d = '0;
        end else if (state_q == StShift) begin
            sreg_d    = {sreg_q[W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    // Serializer datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule
